sprite_line_scheduler: RTL

Per-scanline sprite scheduler sitting beside the 640x480 VGA timing generator. In the front porch of each line it scans a small sprite attribute table and selects up to `MAX_PER_LINE` sprites that intersect the next displayed line. During the active region it composites those sprites by priority into a registered RGB pixel plus hit flag. The top level muxes this pixel into the timing generator's `rin/gin/bin`.

---
 rtl/sprite_line_scheduler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the attribute table in the front porch, composites by priority in the active region.
// Optional build macro SPRITE_OVERFLOW_COUNT_EN enables the per-frame overflowed-line counter on overflow_count.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES  = 8,
  parameter int MAX_PER_LINE = 4,
  parameter int SPRITE_W     = 16,
  parameter int SPRITE_H     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  counterH,
  input  logic [9:0]  counterV,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [9:0]  wr_x,
  input  logic [8:0]  wr_y,
  input  logic [23:0] wr_rgb,
  input  logic        wr_vis,
  output logic        pix_hit,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        line_overflow,
  output logic [7:0]  overflow_count
);

  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int CW = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state;
  logic [IW-1:0] idx;
  logic [8:0]    ny;

  logic [9:0]             tbl_x   [NUM_SPRITES];
  logic [8:0]             tbl_y   [NUM_SPRITES];
  logic [23:0]            tbl_rgb [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] tbl_vis;

  logic [9:0]  b_x     [MAX_PER_LINE];
  logic [23:0] b_rgb   [MAX_PER_LINE];
  logic [CW-1:0] b_cnt;
  logic        b_ovf;
  logic [9:0]  b_x_n   [MAX_PER_LINE];
  logic [23:0] b_rgb_n [MAX_PER_LINE];
  logic [CW-1:0] b_cnt_n;
  logic        b_ovf_n;

  logic [MAX_PER_LINE-1:0] d_valid;
  logic [9:0]  d_x     [MAX_PER_LINE];
  logic [23:0] d_rgb   [MAX_PER_LINE];

  logic [9:0]  y_end;
  logic        qual, last, line_end, start, copy_ok;
  logic [9:0]  sx;
  logic        active, hit_c;
  logic [23:0] rgb_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_vis <= '0;
    end else if (wr_en && ({1'b0, wr_idx} < 5'(NUM_SPRITES))) begin
      tbl_x[wr_idx[IW-1:0]]   <= wr_x;
      tbl_y[wr_idx[IW-1:0]]   <= wr_y;
      tbl_rgb[wr_idx[IW-1:0]] <= wr_rgb;
      tbl_vis[wr_idx[IW-1:0]] <= wr_vis;
    end
  end

  // Sprite bottom computed at 10 bits so sprites near line 479 clip instead of wrapping.
  assign y_end    = {1'b0, tbl_y[idx]} + 10'(SPRITE_H);
  assign qual     = (state == SCAN) && tbl_vis[idx] && (tbl_y[idx] <= ny) && ({1'b0, ny} < y_end);
  assign last     = (idx == IW'(NUM_SPRITES - 1));
  assign line_end = (counterH == 10'd800);
  assign start    = (state == IDLE) && (counterH == 10'd784) &&
                    (counterV >= 10'd35) && (counterV <= 10'd514);
  assign copy_ok  = (state == DONE) || ((state == SCAN) && last);

  always_comb begin
    b_x_n   = b_x;
    b_rgb_n = b_rgb;
    b_cnt_n = b_cnt;
    b_ovf_n = b_ovf;
    if (qual) begin
      if (b_cnt < CW'(MAX_PER_LINE)) begin
        for (int k = 0; k < MAX_PER_LINE; k++) begin
          if (b_cnt == CW'(k)) begin
            b_x_n[k]   = tbl_x[idx];
            b_rgb_n[k] = tbl_rgb[idx];
          end
        end
        b_cnt_n = b_cnt + CW'(1);
      end else begin
        b_ovf_n = 1'b1;
      end
    end
  end

  // The copy at H=800 uses the next-state build list so a scan ending on that cycle is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      ny            <= '0;
      b_cnt         <= '0;
      b_ovf         <= 1'b0;
      d_valid       <= '0;
      line_overflow <= 1'b0;
    end else begin
      b_x   <= b_x_n;
      b_rgb <= b_rgb_n;
      b_cnt <= b_cnt_n;
      b_ovf <= b_ovf_n;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            idx   <= '0;
            ny    <= 9'(counterV - 10'd35);
            b_cnt <= '0;
            b_ovf <= 1'b0;
          end
        end
        SCAN: begin
          if (line_end) begin
            state <= IDLE;
          end else if (last) begin
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (line_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (line_end) begin
        for (int k = 0; k < MAX_PER_LINE; k++) begin
          d_valid[k] <= copy_ok && (CW'(k) < b_cnt_n);
          d_x[k]     <= b_x_n[k];
          d_rgb[k]   <= b_rgb_n[k];
        end
        line_overflow <= copy_ok && b_ovf_n;
      end
    end
  end

  assign sx     = counterH - 10'd145;
  assign active = (counterH > 10'd144) && (counterV > 10'd35);

  // Walk slots from highest to lowest so the lowest slot (lowest sprite index) wins.
  always_comb begin
    hit_c = 1'b0;
    rgb_c = '0;
    if (active) begin
      for (int k = MAX_PER_LINE - 1; k >= 0; k--) begin
        if (d_valid[k] && (d_x[k] <= sx) &&
            ({1'b0, sx} < ({1'b0, d_x[k]} + 11'(SPRITE_W)))) begin
          hit_c = 1'b1;
          rgb_c = d_rgb[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_hit <= 1'b0;
      pix_r   <= '0;
      pix_g   <= '0;
      pix_b   <= '0;
    end else begin
      pix_hit <= hit_c;
      pix_r   <= rgb_c[23:16];
      pix_g   <= rgb_c[15:8];
      pix_b   <= rgb_c[7:0];
    end
  end

`ifdef SPRITE_OVERFLOW_COUNT_EN
  logic [7:0] ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if ((counterH == 10'd0) && (counterV == 10'd0)) begin
      ovf_cnt <= '0;
    end else if (line_end && copy_ok && b_ovf_n && (ovf_cnt != 8'd255)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  assign overflow_count = ovf_cnt;
`else
  assign overflow_count = 8'd0;
`endif

endmodule
